// File: rtl/sched_rr_1to128.sv
// Round-robin scheduler for one broadcast lane shared by 128 requesters.
// Drives the select of the downstream 1-to-128 demux plus a one-hot grant.
// A grant lasts until release, revocation or the MAX_HOLD timeout (0 = no limit).
// Optional feature macro: SCHED_RR_1TO128_LOCK_EN adds a `lock` input that
// suspends the timeout while asserted.
//
// state | meaning
// IDLE  | no grant active, waiting for any request
// GRANT | grant_sel owns the lane, grant_val = 1
module sched_rr_1to128 #(
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] req,
  input  logic         rel,
`ifdef SCHED_RR_1TO128_LOCK_EN
  input  logic         lock,
`endif
  output logic         grant_val,
  output logic [6:0]   grant_sel,
  output logic [127:0] grant_oh
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // Last hcnt value before the timeout fires; unused when MAX_HOLD is 0.
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t       state_q, state_d;
  logic [6:0]   sel_q, sel_d;
  logic [6:0]   ptr_q, ptr_d;
  logic [7:0]   hcnt_q, hcnt_d;
  logic [6:0]   ptr_next;
  logic [127:0] req_masked;
  logic [7:0]   pick_idle;
  logic [7:0]   pick_hand;
  logic         lock_act;
  logic         timeout;
  logic         grant_end;

`ifdef SCHED_RR_1TO128_LOCK_EN
  assign lock_act = lock;
`else
  assign lock_act = 1'b0;
`endif

  // Returns {found, index} of the first set bit scanning upward from p with 7-bit wrap.
  function automatic logic [7:0] pick(input logic [127:0] r, input logic [6:0] p);
    logic       found;
    logic [6:0] idx;
    logic [6:0] win;
    found = 1'b0;
    win   = 7'd0;
    for (int i = 0; i < 128; i++) begin
      idx = p + 7'(i);
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  assign ptr_next   = sel_q + 7'd1;
  assign req_masked = req & ~(128'd1 << sel_q);
  assign pick_idle  = pick(req, ptr_q);
  // The ending holder is masked out so it cannot win its own handoff.
  assign pick_hand  = pick(req_masked, ptr_next);
  assign timeout    = (MAX_HOLD != 0) && (hcnt_q == HOLD_LAST) && !lock_act;
  assign grant_end  = rel || !req[sel_q] || timeout;

  // State, select, pointer and hold-counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= 7'd0;
      ptr_q   <= 7'd0;
      hcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Next-state: arbitrate from IDLE, hand off or hold while in GRANT.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      IDLE: begin
        if (pick_idle[7]) begin
          sel_d   = pick_idle[6:0];
          hcnt_d  = 8'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (grant_end) begin
          ptr_d = ptr_next;
          if (pick_hand[7]) begin
            sel_d  = pick_hand[6:0];
            hcnt_d = 8'd0;
          end else begin
            state_d = IDLE;
          end
        end else if (!lock_act && hcnt_q != 8'hFF) begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_val = (state_q == GRANT);
  assign grant_sel = sel_q;

  // One-hot decode of the registered select, gated by the registered valid.
  always_comb begin
    grant_oh = 128'd0;
    if (grant_val) grant_oh = 128'd1 << sel_q;
  end

endmodule

// File: tb/tb_sched_rr_1to128.sv
// Bench for sched_rr_1to128: two instances (MAX_HOLD=4 and MAX_HOLD=0) share
// stimulus and are compared each cycle to a cycle-count reference model.
module tb_sched_rr_1to128;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] req;
  logic         rel;
  logic         lock;
  logic         gv0, gv1;
  logic [6:0]   gs0, gs1;
  logic [127:0] go0, go1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sched_rr_1to128 #(.MAX_HOLD(4)) dut0 (
    .clk(clk), .reset_n(reset_n), .req(req), .rel(rel),
`ifdef SCHED_RR_1TO128_LOCK_EN
    .lock(lock),
`endif
    .grant_val(gv0), .grant_sel(gs0), .grant_oh(go0)
  );

  sched_rr_1to128 #(.MAX_HOLD(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req), .rel(rel),
`ifdef SCHED_RR_1TO128_LOCK_EN
    .lock(lock),
`endif
    .grant_val(gv1), .grant_sel(gs1), .grant_oh(go1)
  );

  // Reference model: holder, priority start and number of cycles the grant has been visible.
  bit         m_val [2];
  logic [6:0] m_sel [2];
  int         m_ptr [2];
  int         m_cnt [2];
  int         mh    [2] = '{4, 0};
  bit         lock_on = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int scan(input logic [127:0] r, input int p);
    for (int k = 0; k < 128; k++)
      if (r[(p + k) % 128]) return (p + k) % 128;
    return -1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_val[j] = 1'b0; m_sel[j] = 7'd0; m_ptr[j] = 0; m_cnt[j] = 0;
    end
  endtask

  task automatic model_edge();
    int w;
    logic [127:0] rm;
    for (int j = 0; j < 2; j++) begin
      if (!m_val[j]) begin
        w = scan(req, m_ptr[j]);
        if (w >= 0) begin
          m_val[j] = 1'b1; m_sel[j] = 7'(w); m_cnt[j] = 1;
        end
      end else if (rel || !req[m_sel[j]] ||
                   (mh[j] != 0 && !lock_on && m_cnt[j] >= mh[j])) begin
        m_ptr[j] = (int'(m_sel[j]) + 1) % 128;
        rm = req;
        rm[m_sel[j]] = 1'b0;
        w = scan(rm, m_ptr[j]);
        if (w >= 0) begin
          m_sel[j] = 7'(w); m_cnt[j] = 1;
        end else begin
          m_val[j] = 1'b0;
        end
      end else if (!lock_on) begin
        m_cnt[j]++;
      end
    end
  endtask

  function automatic logic [127:0] exp_oh(input int j);
    return m_val[j] ? (128'd1 << m_sel[j]) : 128'd0;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".val0"}, 128'(gv0), 128'(m_val[0]));
    check({tag, ".sel0"}, 128'(gs0), 128'(m_sel[0]));
    check({tag, ".oh0"},  go0, exp_oh(0));
    check({tag, ".val1"}, 128'(gv1), 128'(m_val[1]));
    check({tag, ".sel1"}, 128'(gs1), 128'(m_sel[1]));
    check({tag, ".oh1"},  go1, exp_oh(1));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #2;
    compare_all("rst");
    reset_n = 1'b1;
  endtask

  initial begin
    logic [127:0] r;
    reset_n = 1'b0;
    req     = '1;
    rel     = 1'b0;
    lock    = 1'b0;
    model_reset();
    #3;
    compare_all("reset_hold");
    @(posedge clk); #1;
    compare_all("reset_hold2");
    reset_n = 1'b1;
    step("first_grant");
    check("first_oh", go0, 128'd1);

    // Round robin over 3, 64, 127 with a release every cycle.
    do_reset();
    req = '0; req[3] = 1'b1; req[64] = 1'b1; req[127] = 1'b1;
    rel = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step("rr");
      check("rr_seq", 128'(gs0), 128'((c % 3 == 0) ? 3 : (c % 3 == 1) ? 64 : 127));
    end

    // Wrap and masking: park ptr at 127, then 5 as sole requester.
    do_reset();
    rel = 1'b0; req = '0; req[126] = 1'b1;
    step("wrap_a");
    rel = 1'b1;
    step("wrap_b");
    rel = 1'b0; req = '0; req[5] = 1'b1;
    step("wrap_c");
    check("wrap_g5", 128'(gs0), 128'd5);
    rel = 1'b1;
    step("wrap_d");
    check("wrap_idle", 128'(gv0), 128'd0);
    rel = 1'b0;
    step("wrap_e");
    check("wrap_regrant", go0, 128'd1 << 5);

    // Timeout: MAX_HOLD=4 alternates 10/20, MAX_HOLD=0 keeps 10.
    do_reset();
    req = '0; req[10] = 1'b1; req[20] = 1'b1; rel = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step("tmo");
      check("tmo_seq0", 128'(gs0), 128'((c < 4) ? 10 : (c < 8) ? 20 : 10));
      check("tmo_seq1", 128'(gs1), 128'd10);
    end

    // Revocation of 10 hands to 20, then revoking 20 leaves IDLE.
    do_reset();
    req = '0; req[10] = 1'b1; req[20] = 1'b1;
    step("rev_a");
    req[10] = 1'b0;
    step("rev_b");
    check("rev_to20", 128'(gs1), 128'd20);
    req[20] = 1'b0;
    step("rev_c");
    check("rev_idle", 128'(gv1), 128'd0);

    // Asynchronous reset in the middle of a grant.
    req = '0; req[40] = 1'b1;
    step("mid_a");
    step("mid_b");
    #2;
    do_reset();
    check("mid_rst_oh", go1, 128'd0);

    // Fairness: everyone requesting, one-cycle holds.
    do_reset();
    req = '1; rel = 1'b1;
    for (int c = 0; c < 130; c++) begin
      step("fair");
      check("fair_seq", 128'(gs1), 128'(c % 128));
    end

`ifdef SCHED_RR_1TO128_LOCK_EN
    do_reset();
    req = '0; req[7] = 1'b1; req[8] = 1'b1; rel = 1'b0;
    lock = 1'b1; lock_on = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step("lock");
      check("lock_hold", 128'(gs0), 128'd7);
    end
    lock = 1'b0; lock_on = 1'b0;
    for (int c = 0; c < 6; c++) step("unlock");
`endif

    // Randomized traffic with occasional reset pulses.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = '0;
        if ($urandom_range(0, 19) == 0) r = '1;
        else for (int k = 0; k < int'($urandom_range(0, 4)); k++) r[$urandom_range(0, 127)] = 1'b1;
        req = r;
      end
      rel = ($urandom_range(0, 3) == 0);
`ifdef SCHED_RR_1TO128_LOCK_EN
      lock = ($urandom_range(0, 7) == 0);
      lock_on = lock;
`endif
      if ($urandom_range(0, 99) == 0) do_reset();
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sched_rr_1to128.md
# sched_rr_1to128

Round-robin scheduler sharing one 1-bit broadcast lane among 128 requesters. Each cycle it selects at most one requester, holds the grant until release, revocation or timeout, and drives the 7-bit select and the one-hot grant vector. Together these steer the 1-to-128 demux feeding the requesters. It sits directly upstream of that demux and owns its `sel` input.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one grant may be held. The legal range is 0..255; 0 means unlimited.
- `clk` input 1: clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input 128: request vector; bit i asserted means requester i wants the lane.
- `rel` input 1: current holder releases the grant; ignored while `grant_val`=0.
- `grant_val` output 1: a grant is active this cycle.
- `grant_sel` output 7: index of the granted requester; drives demux `sel`.
- `grant_oh` output 128: one-hot grant.
  - Equals `1 << grant_sel` when `grant_val`=1.
  - Equals all-zero otherwise.

## Operation
- **Internal state**
  - FSM with two states, IDLE and GRANT.
  - 7-bit priority pointer `ptr`.
  - 8-bit hold counter `hcnt`.
- **Reset**
  - State IDLE; `ptr`=0; `hcnt`=0.
  - Outputs: `grant_val`=0, `grant_sel`=0, `grant_oh`=0.
  - Asserting `reset_n` low mid-grant drops the grant immediately, without waiting for a clock edge.
- **Winner selection**
  - The winner is the first i with `req[i]`=1, scanning i = `ptr`, `ptr`+1, …, 127, 0, …, `ptr`-1.
  - Index arithmetic is mod 128; 7-bit wrap.
- **IDLE**
  - If `req` is nonzero, load `grant_sel`=winner, set `grant_val`=1, clear `hcnt`, go to GRANT.
  - Otherwise stay in IDLE with all outputs 0; `grant_sel` keeps its last value.
- **GRANT: end conditions.** The grant ends at the edge where any of these holds:
  - (a) `rel`=1;
  - (b) `req[grant_sel]`=0 (revocation);
  - (c) `MAX_HOLD`≠0 and `hcnt` = `MAX_HOLD`-1.
- **GRANT: when the grant ends**
  - `ptr` becomes `grant_sel`+1 (mod 128).
  - Winner selection is rerun from the new `ptr` in the same edge, using `req` with bit `grant_sel` masked off.
  - If there is a winner, grant it back-to-back: stay in GRANT, clear `hcnt`.
  - If there is none, go to IDLE with `grant_val`=0.
- **GRANT: otherwise**
  - Hold `grant_sel`; `hcnt` increments, saturating at 255.
- **Masking rule**
  - The holder cannot regrant itself on the same edge it ends.
  - If it is the sole requester, it is regranted one IDLE cycle later.
- **Simultaneous end conditions**
  - (a), (b) and (c) together behave the same as any one of them alone.
- **Ignored input**
  - `rel` while in IDLE has no effect.

## Timing
- **Grant latency**
  - `req` sampled high at edge k with scheduler in IDLE → `grant_val`=1 and `grant_sel` valid after edge k.
  - That is one cycle of latency.
- **Handoff**
  - An end condition sampled at edge k → the new holder is visible after edge k.
  - No dead cycle when another requester is pending.
- **Hold limit**
  - With `MAX_HOLD`=N>0 and no release, a grant is visible for exactly N cycles.
- **Output paths**
  - `grant_oh` is combinational from the registered `grant_val`/`grant_sel`.
  - There is no combinational path from any input to any output.
- **Fairness**
  - All 128 requesting continuously, holders releasing after 1 cycle → grants are 0, 1, …, 127, 0, … with one grant per cycle.

## Configuration
- **`SCHED_RR_1TO128_LOCK_EN` defined**
  - Adds input `lock` (1 bit).
  - While `grant_val`=1 and `lock`=1, end condition (c) is suppressed and `hcnt` holds its value.
  - Conditions (a) and (b) still end the grant.
- **`SCHED_RR_1TO128_LOCK_EN` not defined**
  - No `lock` port; the timeout always applies per `MAX_HOLD`.

## Test plan
- **Reset:** `reset_n` low, `req`=all ones → `grant_val`=0, `grant_sel`=0, `grant_oh`=0; first edge after release → `grant_sel`=0, `grant_oh`=0x…0001.
- **Round robin:**
  - Stimulus: `req` bits 3, 64, 127 held, `rel` pulsed every cycle.
  - Required grants: 3, 64, 127, 3, … with no IDLE cycles.
- **Wrap and masking:**
  - Stimulus: `ptr` brought to 127 by granting then releasing 126; then only `req[5]` high, and 5 released.
  - Required: grant 5; after release, `grant_val`=0 for one cycle, then 5 again.
- **Timeout:**
  - Stimulus: `MAX_HOLD`=4, `req[10]` and `req[20]` held, no `rel`.
  - Required: 10 for exactly 4 cycles, then 20 for 4, then 10.
  - Same run with `MAX_HOLD`=0: 10 is held indefinitely.
- **Revocation and mid-operation reset:**
  - Deassert `req[10]` while it holds the grant → next edge grants the next pending requester, or goes IDLE.
  - Assert `reset_n` low mid-grant → outputs zero immediately.
- **Lock (`SCHED_RR_1TO128_LOCK_EN`):**
  - Stimulus: `MAX_HOLD`=2, `lock`=1, `req[7]` and `req[8]` held.
  - Required: 7 held for 10+ cycles; dropping `lock` hands the grant to 8 within 2 cycles.
